dino_jump_controller: RTL and testbench

Frame-synchronous controller that sequences the dino sprite's vertical motion. It accepts the raw jump button and the VGA controller's end-of-frame strobe, and runs a ground/air/cooldown state machine with fixed-point-free integer gravity. It drives the dino `x_coor` and `y_coor` buses consumed by the VGA controller. This replaces the CPU software jump loop for these coordinates: the controller owns the jump counter, height and button status, and the handshake with the screen-end strobe.

---
 rtl/dino_jump_controller_if.sv | 27 ++
 rtl/dino_jump_controller.sv | 119 +++++++++++
 tb/tb_dino_jump_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dino_jump_controller_if.sv
// Dino jump controller bus: button/frame inputs and sprite coordinate outputs.
interface dino_jump_controller_if;
  logic        jump;
  logic        screenEnd;
  logic [31:0] x_coor;
  logic [31:0] y_coor;
  logic        airborne;
  logic        frame_done;

  modport master (
    output jump,
    output screenEnd,
    input  x_coor,
    input  y_coor,
    input  airborne,
    input  frame_done
  );

  modport slave (
    input  jump,
    input  screenEnd,
    output x_coor,
    output y_coor,
    output airborne,
    output frame_done
  );
endinterface

// File: rtl/dino_jump_controller.sv
// Frame-synchronous dino jump sequencer: ground / air / cooldown with integer gravity.
module dino_jump_controller #(
  parameter int unsigned GROUND_Y = 400,
  parameter int unsigned X_POS    = 100,
  parameter int unsigned JUMP_V0  = 18,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned COOLDOWN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  dino_jump_controller_if.slave  bus
);

  typedef enum logic [1:0] {
    S_GROUND,
    S_AIR,
    S_COOL
  } state_t;

  localparam logic [9:0]        GROUND_Y_C = 10'(GROUND_Y);
  localparam logic [9:0]        LAUNCH_Y   = 10'(GROUND_Y - JUMP_V0);
  localparam logic signed [7:0] LAUNCH_V   = 8'(JUMP_V0 - GRAVITY);
  localparam logic signed [7:0] GRAVITY_C  = 8'(GRAVITY);
  localparam logic [3:0]        CD_INIT    = 4'(COOLDOWN);

  state_t             state;
  logic [9:0]         y;
  logic signed [7:0]  v;
  logic [3:0]         cd;
  logic               pending;
  logic               airborne_q;
  logic               frame_done_q;
  logic               js1, js2, js_q;
  logic               se_q;

  logic               press;
  logic               tick;
  logic signed [10:0] y_next;

  assign press  = js2 & ~js_q;
  assign tick   = bus.screenEnd & ~se_q;
  // Upward velocity is positive while rows grow downward, hence y - v.
  assign y_next = $signed({1'b0, y}) - 11'(v);

  assign bus.x_coor     = 32'(X_POS);
  assign bus.y_coor     = {22'd0, y};
  assign bus.airborne   = airborne_q;
  assign bus.frame_done = frame_done_q;

  // Button synchronizer, edge detectors and the ground/air/cooldown state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_GROUND;
      y            <= GROUND_Y_C;
      v            <= '0;
      cd           <= '0;
      pending      <= 1'b0;
      airborne_q   <= 1'b0;
      frame_done_q <= 1'b0;
      // Preset high so a button or strobe held across reset release is not an edge.
      js1          <= 1'b1;
      js2          <= 1'b1;
      js_q         <= 1'b1;
      se_q         <= 1'b1;
    end else begin
      js1          <= bus.jump;
      js2          <= js1;
      js_q         <= js2;
      se_q         <= bus.screenEnd;
      frame_done_q <= tick;

      case (state)
        S_GROUND: begin
          if (tick && (pending || press)) begin
            y          <= LAUNCH_Y;
            v          <= LAUNCH_V;
            pending    <= 1'b0;
            airborne_q <= 1'b1;
            state      <= S_AIR;
          end else if (press) begin
            pending <= 1'b1;
          end
        end

        S_AIR: begin
          if (tick) begin
            if (y_next >= $signed({1'b0, GROUND_Y_C})) begin
              y          <= GROUND_Y_C;
              v          <= '0;
              cd         <= CD_INIT;
              airborne_q <= 1'b0;
              state      <= (COOLDOWN == 0) ? S_GROUND : S_COOL;
            end else begin
              y <= y_next[9:0];
              v <= v - GRAVITY_C;
            end
          end
        end

        S_COOL: begin
          if (tick) begin
            if (cd <= 4'd1) begin
              cd    <= '0;
              state <= S_GROUND;
            end else begin
              cd <= cd - 4'd1;
            end
          end
        end

        default: begin
          state      <= S_GROUND;
          airborne_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dino_jump_controller.sv
// Scoreboard bench for dino_jump_controller: stimulus pushes expected per-frame
// coordinates, a monitor pops and compares on every frame_done pulse.
module tb_dino_jump_controller;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dino_jump_controller_if bus ();

  dino_jump_controller #(
    .GROUND_Y (400),
    .X_POS    (100),
    .JUMP_V0  (18),
    .GRAVITY  (1),
    .COOLDOWN (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int y;
    int air;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   n_fd   = 0;
  int   n_push = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Closed-form height after tick k of a jump (k >= 1): 400 - sum_{i=0}^{k-1}(18 - i).
  function automatic int ypos(input int k);
    return 400 - 18 * k + (k * (k - 1)) / 2;
  endfunction

  task automatic expect_frame(input int ey, input int ea);
    exp_t e;
    e.y   = ey;
    e.air = ea;
    sb.push_back(e);
    n_push++;
  endtask

  // One screenEnd strobe; caller is at a negedge.
  task automatic frame(input int ey, input int ea);
    expect_frame(ey, ea);
    bus.screenEnd = 1'b1;
    @(negedge clk);
    bus.screenEnd = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Button pulse between frames; press becomes visible at the 3rd rising edge.
  task automatic press_btn();
    bus.jump = 1'b1;
    repeat (4) @(negedge clk);
    bus.jump = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: every frame_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && bus.frame_done === 1'b1) begin
      n_fd++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_done: got pulse expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("tick_y", bus.y_coor, 32'(e.y));
        check("tick_airborne", {31'd0, bus.airborne}, 32'(e.air));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.jump      = 1'b1;
    bus.screenEnd = 1'b0;
    #1;
    check("reset_y", bus.y_coor, 32'd400);
    check("reset_airborne", {31'd0, bus.airborne}, 32'd0);
    check("reset_x", bus.x_coor, 32'd100);
    check("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Button held through reset release: no launch over 5 frames.
    for (int i = 0; i < 5; i++) frame(400, 0);
    check("held_jump_x", bus.x_coor, 32'd100);
    bus.jump = 1'b0;
    repeat (4) @(negedge clk);

    // Press between ticks, then a full jump; press at tick 10 is ignored.
    press_btn();
    for (int k = 1; k <= 37; k++) begin
      frame(ypos(k), (k < 37) ? 1 : 0);
      if (k == 10) press_btn();
    end
    check("landed_y", bus.y_coor, 32'd400);

    // Press in cooldown is discarded; two cooldown ticks then one idle ground tick.
    press_btn();
    frame(400, 0);
    frame(400, 0);
    frame(400, 0);

    // New press after cooldown launches on the following tick.
    press_btn();
    for (int k = 1; k <= 10; k++) frame(ypos(k), 1);
    check("tick10_y", bus.y_coor, 32'd265);

    // Reset mid-jump aborts asynchronously.
    #2;
    reset = 1'b1;
    #1;
    check("abort_y", bus.y_coor, 32'd400);
    check("abort_airborne", {31'd0, bus.airborne}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    frame(400, 0);
    frame(400, 0);

    // Press coinciding with the screenEnd rise launches on that tick.
    expect_frame(382, 1);
    bus.jump = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.screenEnd = 1'b1;
    @(negedge clk);
    bus.screenEnd = 1'b0;
    repeat (3) @(negedge clk);
    bus.jump = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // screenEnd held high for 10 cycles yields exactly one tick.
    expect_frame(400, 0);
    bus.screenEnd = 1'b1;
    repeat (10) @(negedge clk);
    bus.screenEnd = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_drained", 32'(sb.size()), 32'd0);
    check("frame_done_count", 32'(n_fd), 32'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
